// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: arbiter FSM states and byte type,
// also used by the uart_top sequencers.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } arb_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, as a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ frame sources: round-robin per frame,
// pulls bytes over valid/ready and paces them into uart_tx via send_en/busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BUSY_TO = 64,
  parameter int unsigned GAP_CYC = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][7:0] src_data,
  input  logic [NUM_REQ-1:0]      src_valid,
  input  logic [NUM_REQ-1:0]      src_last,
  output logic [NUM_REQ-1:0]      src_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    frame_done,
  output logic                    tx_err
);

  localparam int unsigned   IW       = $clog2(NUM_REQ);
  localparam int unsigned   TW       = cnt_width(BUSY_TO);
  localparam int unsigned   GW       = cnt_width(GAP_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  arb_state_t        state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              tx_en_q, tx_en_d;
  byte_t             tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic              frame_done_q, frame_done_d;
  logic              tx_err_q, tx_err_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic          sel_valid;
  logic          sel_last;
  logic          sel_req;
  byte_t         sel_data;
  logic [IW-1:0] next_ptr;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_valid = src_valid[idx_q];
  assign sel_last  = src_last[idx_q];
  assign sel_req   = req[idx_q];
  assign sel_data  = src_data[idx_q];
  assign next_ptr  = IW'((32'(idx_q) + 32'd1) % NUM_REQ);

  always_comb begin
    src_ready = '0;
    if (state_q == ST_FETCH) src_ready[idx_q] = src_valid[idx_q];
  end

  // tx_en is raised straight out of FETCH when the line is free, so SEND
  // only retires the pulse (or waits for a leftover busy to clear).
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    tx_err_d     = tx_err_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (sel_valid) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          tx_en_d   = !tx_busy;
          state_d   = ST_SEND;
        end else if (!sel_req) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_en_q) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT_HI;
        end else if (!tx_busy) begin
          tx_en_d = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (to_cnt_q == TO_LAST) begin
          tx_err_d = 1'b1;
          state_d  = ST_WAIT_LO;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            frame_done_d = 1'b1;
            ptr_d        = next_ptr;
            grant_d      = '0;
            gap_cnt_d    = '0;
            state_d      = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      tx_err_q     <= tx_err_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple uart_tx
// busy model and per-source byte streams.
module tb_uart_tx_arbiter;

  localparam int BUSY_TO  = 20;
  localparam int GAP_CYC  = 8;
  localparam int BUSY_CYC = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][7:0] src_data;
  logic [3:0]      src_valid;
  logic [3:0]      src_last;
  logic [3:0]      src_ready;
  logic [3:0]      grant;
  logic            tx_en;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            frame_done;
  logic            tx_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .BUSY_TO (BUSY_TO),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .grant      (grant),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .tx_err     (tx_err)
  );

  // Source streams: bytes appended by the stimulus, consumed on valid&ready.
  logic [7:0] smem  [4][64];
  logic       slast [4][64];
  int         avail [4] = '{0, 0, 0, 0};
  int         pos   [4] = '{0, 0, 0, 0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    assign src_valid[gi] = (pos[gi] < avail[gi]);
    assign src_data[gi]  = smem[gi][pos[gi][5:0]];
    assign src_last[gi]  = slast[gi][pos[gi][5:0]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (src_valid[i] && src_ready[i]) pos[i] <= pos[i] + 1;
  end

  // uart_tx model: busy rises one cycle after send_en, holds BUSY_CYC cycles.
  int busy_cnt   = 0;
  bit never_busy = 1'b0;
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_en && !never_busy) busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  // Event log, sampled 1 time unit after each rising edge.
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_cyc[$];
  logic [3:0] g_log[$];
  int         g_cyc[$];
  logic [7:0] b_data[$];
  logic [3:0] b_grant[$];
  int         b_cyc[$];
  int         terr_cyc = -1;
  logic [3:0] prev_grant = '0;
  logic       prev_err = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc.push_back(cyc);
    end
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      g_log.push_back(grant);
      g_cyc.push_back(cyc);
    end
    prev_grant = grant;
    if (tx_en === 1'b1) begin
      b_data.push_back(tx_data);
      b_grant.push_back(grant);
      b_cyc.push_back(cyc);
    end
    if (tx_err === 1'b1 && !prev_err) terr_cyc = cyc;
    prev_err = tx_err;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input logic l);
    smem[s][avail[s][5:0]]  = b;
    slast[s][avail[s][5:0]] = l;
    avail[s] = avail[s] + 1;
  endtask

  task automatic wait_fd(input int target, input string tag);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, fd_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    fb, gb, bb, kreq, n;
    string s3;
    s3    = "Code:0123456789ABCDE";
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant", grant, 4'b0);
    check("rst_src_ready", src_ready, 4'b0);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tx_err", tx_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting, one-byte frames: order 0,1,2,3,0 with GAP_CYC gaps
    push_byte(0, 8'h10, 1'b1);
    push_byte(0, 8'h11, 1'b1);
    push_byte(1, 8'h20, 1'b1);
    push_byte(2, 8'h30, 1'b1);
    push_byte(3, 8'h40, 1'b1);
    fb = fd_cnt; gb = g_log.size();
    req  = 4'b1111;
    kreq = cyc;
    wait_fd(fb + 5, "t2_frames");
    req = 4'b0000;
    check("t2_latency", g_cyc[gb] - kreq, 1);
    check("t2_g0", g_log[gb],     4'b0001);
    check("t2_g1", g_log[gb + 1], 4'b0010);
    check("t2_g2", g_log[gb + 2], 4'b0100);
    check("t2_g3", g_log[gb + 3], 4'b1000);
    check("t2_g4", g_log[gb + 4], 4'b0001);
    for (int k = 0; k < 4; k++)
      check("t2_gap", g_cyc[gb + k + 1] - fd_cyc[fb + k], GAP_CYC + 1);

    // Single source 0, "Hi\r\n"
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b0);
    push_byte(0, 8'h0D, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    fb = fd_cnt; bb = b_data.size();
    req = 4'b0001;
    wait_fd(fb + 1, "t1_frame");
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("t1_count", b_data.size() - bb, 4);
    check("t1_b0", {b_grant[bb],     b_data[bb]},     {4'b0001, 8'h48});
    check("t1_b1", {b_grant[bb + 1], b_data[bb + 1]}, {4'b0001, 8'h69});
    check("t1_b2", {b_grant[bb + 2], b_data[bb + 2]}, {4'b0001, 8'h0D});
    check("t1_b3", {b_grant[bb + 3], b_data[bb + 3]}, {4'b0001, 8'h0A});
    check("t1_one_done", fd_cnt, fb + 1);

    // Source 2 requests while source 1 sends a 20-byte frame
    for (int i = 0; i < 20; i++) push_byte(1, s3[i], (i == 19));
    push_byte(2, 8'h4F, 1'b0);
    push_byte(2, 8'h4B, 1'b1);
    fb = fd_cnt; bb = b_data.size();
    req = 4'b0010;
    repeat (5) @(negedge clk);
    req = 4'b0110;
    wait_fd(fb + 1, "t3_frame1");
    req = 4'b0100;
    wait_fd(fb + 2, "t3_frame2");
    req = 4'b0000;
    for (int i = 0; i < 20; i++)
      check("t3_byte", {b_grant[bb + i], b_data[bb + i]}, {4'b0010, s3[i]});
    check("t3_next_src", {b_grant[bb + 20], b_data[bb + 20]}, {4'b0100, 8'h4F});
    check("t3_no_interleave", b_cyc[bb + 20] > fd_cyc[fb], 1'b1);

    // uart never raises busy: sticky tx_err, frame still completes
    check("t4_err_before", tx_err, 1'b0);
    never_busy = 1'b1;
    push_byte(3, 8'hA1, 1'b0);
    push_byte(3, 8'hA2, 1'b0);
    push_byte(3, 8'hA3, 1'b1);
    fb = fd_cnt; bb = b_data.size();
    req = 4'b1000;
    wait_fd(fb + 1, "t4_frame");
    req = 4'b0000;
    never_busy = 1'b0;
    check("t4_err_after", tx_err, 1'b1);
    check("t4_err_time", terr_cyc - b_cyc[bb], BUSY_TO + 1);
    check("t4_b0", {b_grant[bb],     b_data[bb]},     {4'b1000, 8'hA1});
    check("t4_b1", {b_grant[bb + 1], b_data[bb + 1]}, {4'b1000, 8'hA2});
    check("t4_b2", {b_grant[bb + 2], b_data[bb + 2]}, {4'b1000, 8'hA3});

    // Back-to-back frames from sources 0 and 1: exactly GAP_CYC idle cycles
    push_byte(0, 8'h55, 1'b1);
    push_byte(1, 8'h66, 1'b1);
    fb = fd_cnt; gb = g_log.size();
    req = 4'b0011;
    wait_fd(fb + 1, "t5_frame1");
    req = 4'b0010;
    wait_fd(fb + 2, "t5_frame2");
    req = 4'b0000;
    check("t5_g0", g_log[gb],     4'b0001);
    check("t5_g1", g_log[gb + 1], 4'b0010);
    check("t5_gap", g_cyc[gb + 1] - fd_cyc[fb], GAP_CYC + 1);

    // Reset during the third byte of a source-2 frame
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b0);
    push_byte(2, 8'h43, 1'b0);
    push_byte(2, 8'h44, 1'b0);
    push_byte(2, 8'h45, 1'b1);
    bb = b_data.size();
    req = 4'b0100;
    n = 0;
    while (b_data.size() < bb + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t6_third_byte", b_data.size(), bb + 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, 4'b0);
    check("t6_rst_tx_en", tx_en, 1'b0);
    check("t6_rst_src_ready", src_ready, 4'b0);
    check("t6_rst_tx_data", tx_data, 8'h00);
    req = 4'b0000;
    push_byte(1, 8'h78, 1'b1);
    push_byte(3, 8'h79, 1'b1);
    repeat (2) @(negedge clk);
    fb = fd_cnt; gb = g_log.size();
    req   = 4'b1010;
    rst_n = 1'b1;
    wait_fd(fb + 1, "t6_frame1");
    req = 4'b1000;
    wait_fd(fb + 2, "t6_frame2");
    req = 4'b0000;
    check("t6_ptr0_grant", g_log[gb], 4'b0010);
    check("t6_err_cleared", tx_err, 1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
